// File: rtl/arm_multicycle_controller.sv
// Multicycle sequencer for the ARM-subset datapath: state machine,
// per-state selects and enables, NZCV flag register and condition check.
//
// Ports:
//   clk, reset  rising-edge clock; asynchronous active-high reset
//   Instr       IR bits [31:12] = {cond, op, funct, rn, rd}
//   ALUFlags    {N,Z,C,V} from the ALU
//   MemReady    memory completes the current access this cycle
//   PCWrite .. ResultSrc  datapath enables and mux selects
//   MemTimeout  one-cycle pulse after the wait limit is hit
//   Flags       current NZCV register
module arm_multicycle_controller #(
  parameter int MAX_WAIT = 0,
  parameter int WAIT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ImmSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ResultSrc,
  output logic        MemTimeout,
  output logic [3:0]  Flags
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_e;

  localparam bit TMO_EN = (MAX_WAIT != 0);
  // Count value seen during the MAX_WAIT-th stalled cycle.
  localparam logic [WAIT_W-1:0] WAIT_LIM =
    WAIT_W'(TMO_EN ? MAX_WAIT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_SAT = '1;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic [3:0] rd;
  logic       s_bit;
  logic       l_bit;
  logic       i_bit;
  logic       rd_pc;
  logic       unused_rn;

  assign cond      = Instr[19:16];
  assign op        = Instr[15:14];
  assign funct     = Instr[13:8];
  assign cmd       = funct[4:1];
  assign i_bit     = funct[5];
  assign s_bit     = funct[0];
  assign l_bit     = funct[0];
  assign rd        = Instr[3:0];
  assign rd_pc     = (rd == 4'hF);
  assign unused_rn = ^Instr[7:4];

  // State
  state_e            state_q, state_d;
  logic [3:0]        flags_q, flags_d;
  logic              cond_ex_q, cond_ex_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic       cond_pass;
  logic [1:0] alu_op;
  logic       is_arith;
  logic       mem_state;
  logic       timeout_hit;

  // Unqualified enables, gated with reset below
  logic pc_w;
  logic mem_w;
  logic ir_w;
  logic reg_w;

  // ARM condition table against the stored flags
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_pass = 1'b0;
    unique case (cond)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = c;
      4'h3: cond_pass = !c;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = c && !z;
      4'h9: cond_pass = !c || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      4'hE: cond_pass = 1'b1;
      4'hF: cond_pass = 1'b0;
    endcase
  end

  // Data-processing command decode
  always_comb begin
    alu_op = 2'b00;
    unique case (cmd)
      4'b0100: alu_op = 2'b00;
      4'b0010: alu_op = 2'b01;
      4'b0000: alu_op = 2'b10;
      4'b1100: alu_op = 2'b11;
      default: alu_op = 2'b00;
    endcase
  end

  assign is_arith = (cmd == 4'b0100) || (cmd == 4'b0010);

  assign mem_state = (state_q == S_FETCH)   ||
                     (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

  assign timeout_hit = TMO_EN && mem_state && !MemReady &&
                       (wait_cnt_q == WAIT_LIM);

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (MemReady) state_d = S_DECODE;
      S_DECODE:
        unique case (op)
          2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      S_MEMADR:
        state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:
        if (MemReady) state_d = S_MEMWB;
      S_MEMWB:
        state_d = S_FETCH;
      S_MEMWRITE:
        if (MemReady) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:
        state_d = S_ALUWB;
      S_ALUWB,
      S_BRANCH:
        state_d = S_FETCH;
      default:
        state_d = S_FETCH;
    endcase
    // An abandoned access restarts at fetch
    if (timeout_hit) state_d = S_FETCH;
  end

  // Wait counter: stalled cycles in the current memory state
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (timeout_hit || (state_d != state_q))
      wait_cnt_d = '0;
    else if (mem_state && !MemReady && (wait_cnt_q != WAIT_SAT))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  assign mem_timeout_d = timeout_hit;

  // Condition is sampled once per instruction, in decode
  assign cond_ex_d = (state_q == S_DECODE) ? cond_pass : cond_ex_q;

  // Flags: N,Z for any S-suffixed op; C,V only from the adder
  always_comb begin
    flags_d = flags_q;
    if (((state_q == S_EXECR) || (state_q == S_EXECI)) &&
        s_bit && cond_ex_q) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (is_arith) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Per-state controls
  always_comb begin
    pc_w       = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    ResultSrc  = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_w      = MemReady;
        pc_w      = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        if (rd_pc) pc_w  = cond_ex_q;
        else       reg_w = cond_ex_q;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_w  = cond_ex_q;
      end
      S_EXECR: begin
        ALUControl = alu_op;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_op;
      end
      S_ALUWB: begin
        if (rd_pc) pc_w  = cond_ex_q;
        else       reg_w = cond_ex_q;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pc_w      = cond_ex_q;
      end
      default: begin
        pc_w = 1'b0;
      end
    endcase
  end

  // Instruction-static decode, valid in every state
  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      2'b01:   ImmSrc = 2'b01;
      2'b10:   ImmSrc = 2'b10;
      default: ImmSrc = 2'b00;
    endcase
  end

  assign RegSrc = {(op == 2'b01) && !l_bit, op == 2'b10};

  // Reset overrides enables immediately, not at the next edge
  assign PCWrite  = pc_w  && !reset;
  assign MemWrite = mem_w && !reset;
  assign IRWrite  = ir_w  && !reset;
  assign RegWrite = reg_w && !reset;

  assign MemTimeout = mem_timeout_q;
  assign Flags      = flags_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FETCH;
      flags_q       <= 4'b0000;
      cond_ex_q     <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      cond_ex_q     <= cond_ex_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for arm_multicycle_controller: a per-cycle vector
// table plus hand sequences for stalls, timeout and mid-access reset.
module tb_arm_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = 20'hE2802;
  logic [3:0]  ALUFlags = 4'h0;
  logic        MemReady = 1'b1;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
  logic       ALUSrcA, MemTimeout;
  logic [3:0] Flags;

  logic       t_PCWrite, t_AdrSrc, t_MemWrite, t_IRWrite, t_RegWrite;
  logic [1:0] t_RegSrc, t_ImmSrc, t_ALUSrcB, t_ALUControl, t_ResultSrc;
  logic       t_ALUSrcA, t_MemTimeout;
  logic [3:0] t_Flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arm_multicycle_controller u_dut (
    .clk(clk), .reset(reset), .Instr(Instr),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegSrc(RegSrc),
    .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .MemTimeout(MemTimeout), .Flags(Flags)
  );

  arm_multicycle_controller #(.MAX_WAIT(4), .WAIT_W(8)) u_tmo (
    .clk(clk), .reset(reset), .Instr(Instr),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(t_PCWrite), .AdrSrc(t_AdrSrc), .MemWrite(t_MemWrite),
    .IRWrite(t_IRWrite), .RegWrite(t_RegWrite), .RegSrc(t_RegSrc),
    .ImmSrc(t_ImmSrc), .ALUSrcA(t_ALUSrcA), .ALUSrcB(t_ALUSrcB),
    .ALUControl(t_ALUControl), .ResultSrc(t_ResultSrc),
    .MemTimeout(t_MemTimeout), .Flags(t_Flags)
  );

  // {PCW,Adr,MW,IRW,RW,RegSrc,ImmSrc,SrcA,SrcB,ALUC,Res,Tmo,Flags}
  logic [20:0] act;
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ALUControl,
                ResultSrc, MemTimeout, Flags};

  typedef struct {
    logic        rst;
    logic [19:0] instr;
    logic [3:0]  alf;
    logic        rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic r, input logic [19:0] i,
                              input logic [3:0] f, input logic m,
                              input logic [20:0] e);
    vec_t v;
    v.rst = r; v.instr = i; v.alf = f; v.rdy = m; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic step(input logic rdy, input logic [19:0] ins,
                      input logic [3:0] af);
    @(negedge clk);
    reset = 1'b0;
    MemReady = rdy;
    Instr = ins;
    ALUFlags = af;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Reset: enables gated even though FETCH sees MemReady=1
    vt.push_back(mk(1, 20'hE2802, 4'h0, 1, 21'b0_0_0_0_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(1, 20'hE2802, 4'h0, 1, 21'b0_0_0_0_0_00_00_1_10_00_10_0_0000));
    // ADD R2,R0,#5
    vt.push_back(mk(0, 20'hE2802, 4'h0, 1, 21'b1_0_0_1_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE2802, 4'h0, 1, 21'b0_0_0_0_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE2802, 4'h0, 1, 21'b0_0_0_0_0_00_00_0_01_00_00_0_0000));
    vt.push_back(mk(0, 20'hE2802, 4'h0, 1, 21'b0_0_0_0_1_00_00_0_00_00_00_0_0000));
    // ADD PC,R0,#imm: PC write instead of register write
    vt.push_back(mk(0, 20'hE280F, 4'h0, 1, 21'b1_0_0_1_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE280F, 4'h0, 1, 21'b0_0_0_0_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE280F, 4'h0, 1, 21'b0_0_0_0_0_00_00_0_01_00_00_0_0000));
    vt.push_back(mk(0, 20'hE280F, 4'h0, 1, 21'b1_0_0_0_0_00_00_0_00_00_00_0_0000));
    // LDR R1,[R0]
    vt.push_back(mk(0, 20'hE5901, 4'h0, 1, 21'b1_0_0_1_0_00_01_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE5901, 4'h0, 1, 21'b0_0_0_0_0_00_01_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE5901, 4'h0, 1, 21'b0_0_0_0_0_00_01_0_01_00_00_0_0000));
    vt.push_back(mk(0, 20'hE5901, 4'h0, 1, 21'b0_1_0_0_0_00_01_0_00_00_00_0_0000));
    vt.push_back(mk(0, 20'hE5901, 4'h0, 1, 21'b0_0_0_0_1_00_01_0_00_00_01_0_0000));
    // STR R1,[R0]
    vt.push_back(mk(0, 20'hE5801, 4'h0, 1, 21'b1_0_0_1_0_10_01_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE5801, 4'h0, 1, 21'b0_0_0_0_0_10_01_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE5801, 4'h0, 1, 21'b0_0_0_0_0_10_01_0_01_00_00_0_0000));
    vt.push_back(mk(0, 20'hE5801, 4'h0, 1, 21'b0_1_1_0_0_10_01_0_00_00_00_0_0000));
    // SUBS R3,R0,R0 with ALU reporting Z
    vt.push_back(mk(0, 20'hE0503, 4'h4, 1, 21'b1_0_0_1_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE0503, 4'h4, 1, 21'b0_0_0_0_0_00_00_1_10_00_10_0_0000));
    vt.push_back(mk(0, 20'hE0503, 4'h4, 1, 21'b0_0_0_0_0_00_00_0_00_01_00_0_0000));
    vt.push_back(mk(0, 20'hE0503, 4'hF, 1, 21'b0_0_0_0_1_00_00_0_00_00_00_0_0100));
    // BEQ taken; ALUFlags=F must not leak into Flags
    vt.push_back(mk(0, 20'h0A000, 4'hF, 1, 21'b1_0_0_1_0_01_10_1_10_00_10_0_0100));
    vt.push_back(mk(0, 20'h0A000, 4'hF, 1, 21'b0_0_0_0_0_01_10_1_10_00_10_0_0100));
    vt.push_back(mk(0, 20'h0A000, 4'hF, 1, 21'b1_0_0_0_0_01_10_0_01_00_10_0_0100));
    // BNE not taken
    vt.push_back(mk(0, 20'h1A000, 4'hF, 1, 21'b1_0_0_1_0_01_10_1_10_00_10_0_0100));
    vt.push_back(mk(0, 20'h1A000, 4'hF, 1, 21'b0_0_0_0_0_01_10_1_10_00_10_0_0100));
    vt.push_back(mk(0, 20'h1A000, 4'hF, 1, 21'b0_0_0_0_0_01_10_0_01_00_10_0_0100));

    foreach (vt[i]) begin
      @(negedge clk);
      reset = vt[i].rst;
      Instr = vt[i].instr;
      ALUFlags = vt[i].alf;
      MemReady = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d", i), 32'(act), 32'(vt[i].exp));
    end

    // Three-cycle stall in FETCH
    for (int k = 0; k < 3; k++) begin
      step(0, 20'hE2802, 4'h0);
      chk($sformatf("fstall%0d_irw", k), IRWrite, 0);
      chk($sformatf("fstall%0d_pcw", k), PCWrite, 0);
    end
    step(1, 20'hE2802, 4'h0);
    chk("fstall_done_irw", IRWrite, 1);
    chk("fstall_done_pcw", PCWrite, 1);
    step(1, 20'hE2802, 4'h0);
    chk("fstall_dec_irw", IRWrite, 0);
    step(1, 20'hE2802, 4'h0);
    chk("fstall_exi_srcb", ALUSrcB, 2'b01);
    step(1, 20'hE2802, 4'h0);
    chk("fstall_wb_rw", RegWrite, 1);

    // Three-cycle stall in MEMWRITE
    step(1, 20'hE5801, 4'h0);
    step(1, 20'hE5801, 4'h0);
    step(1, 20'hE5801, 4'h0);
    chk("wstall_memadr_srcb", ALUSrcB, 2'b01);
    for (int k = 0; k < 3; k++) begin
      step(0, 20'hE5801, 4'h0);
      chk($sformatf("wstall%0d_mw", k), MemWrite, 1);
      chk($sformatf("wstall%0d_rw", k), RegWrite, 0);
    end
    step(1, 20'hE5801, 4'h0);
    chk("wstall_last_mw", MemWrite, 1);
    step(1, 20'hE2802, 4'h0);
    chk("wstall_fetch_mw", MemWrite, 0);
    chk("wstall_fetch_irw", IRWrite, 1);
    step(1, 20'hE2802, 4'h0);
    step(1, 20'hE2802, 4'h0);
    step(1, 20'hE2802, 4'h0);

    // Reset asserted mid-MEMWRITE
    step(1, 20'hE5801, 4'h0);
    step(1, 20'hE5801, 4'h0);
    step(1, 20'hE5801, 4'h0);
    step(0, 20'hE5801, 4'h0);
    chk("rst_pre_mw", MemWrite, 1);
    chk("rst_pre_flags", Flags, 4'h4);
    #2;
    reset = 1'b1;
    MemReady = 1'b1;
    #1;
    chk("rst_async_mw", MemWrite, 0);
    chk("rst_async_flags", Flags, 4'h0);
    chk("rst_async_adr", AdrSrc, 0);
    chk("rst_async_irw", IRWrite, 0);
    step(1, 20'hE2802, 4'h0);
    chk("rst_fetch_irw", IRWrite, 1);
    chk("rst_fetch_pcw", PCWrite, 1);
    step(1, 20'hE2802, 4'h0);
    chk("rst_dec_srca", ALUSrcA, 1);
    step(1, 20'hE2802, 4'h0);
    step(1, 20'hE2802, 4'h0);
    chk("rst_wb_rw", RegWrite, 1);

    // Timeout in MEMREAD (MAX_WAIT=4 instance)
    step(1, 20'hE5901, 4'h0);
    step(1, 20'hE5901, 4'h0);
    step(1, 20'hE5901, 4'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 20'hE5901, 4'h0);
      chk($sformatf("tmo%0d_adr", k), t_AdrSrc, 1);
      chk($sformatf("tmo%0d_pulse", k), t_MemTimeout, 0);
      chk($sformatf("tmo%0d_rw", k), t_RegWrite, 0);
    end
    step(0, 20'hE5901, 4'h0);
    chk("tmo_pulse", t_MemTimeout, 1);
    chk("tmo_fetch_adr", t_AdrSrc, 0);
    chk("tmo_fetch_srca", t_ALUSrcA, 1);
    chk("tmo_fetch_rw", t_RegWrite, 0);
    chk("tmo_fetch_irw", t_IRWrite, 0);
    chk("notmo_adr", AdrSrc, 1);
    chk("notmo_pulse", MemTimeout, 0);
    step(0, 20'hE5901, 4'h0);
    chk("tmo_pulse_end", t_MemTimeout, 0);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
